// File: rtl/xm_skid_latch.sv
// ============================================================================
// Module : xm_skid_latch
// X/M pipeline latch: valid/ready handshake, optional skid entry, flush and
// bubble zeroing of the control/destination fields.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module xm_skid_latch #(
  parameter int PC_W   = 32,
  parameter int DATA_W = 32,
  parameter int CTRL_W = 14,
  parameter int RD_W   = 5,
  parameter int SKID   = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PC_W-1:0]   in_pc_next,
  input  logic [PC_W-1:0]   in_pc_plus1,
  input  logic [DATA_W-1:0] in_alu_result,
  input  logic [DATA_W-1:0] in_data_reg,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [RD_W-1:0]   in_rd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PC_W-1:0]   out_pc_next,
  output logic [PC_W-1:0]   out_pc_plus1,
  output logic [DATA_W-1:0] out_alu_result,
  output logic [DATA_W-1:0] out_data_reg,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [RD_W-1:0]   out_rd,
  output logic [1:0]        out_count
);

  localparam int PL_W = 2 * PC_W + 2 * DATA_W + CTRL_W + RD_W;

  logic [PL_W-1:0]   w_in_pl;
  logic [PL_W-1:0]   r_m_pl;
  logic              r_m_valid;
  logic              w_in_fire;
  logic              w_out_fire;
  logic [CTRL_W-1:0] w_m_ctrl;
  logic [RD_W-1:0]   w_m_rd;

  assign w_in_pl    = {in_pc_next, in_pc_plus1, in_alu_result, in_data_reg, in_ctrl, in_rd};
  assign w_in_fire  = in_valid & in_ready;
  assign w_out_fire = r_m_valid & out_ready;

  assign {out_pc_next, out_pc_plus1, out_alu_result, out_data_reg, w_m_ctrl, w_m_rd} = r_m_pl;
  assign out_valid = r_m_valid;

  // An empty slot must look like a NOP downstream: no control, no writeback.
  assign out_ctrl = r_m_valid ? w_m_ctrl : '0;
  assign out_rd   = r_m_valid ? w_m_rd   : '0;

  generate
    if (SKID != 0) begin : g_skid
      logic [PL_W-1:0] r_s_pl;
      logic            r_s_valid;

      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          r_m_valid <= 1'b0;
          r_m_pl    <= '0;
          r_s_valid <= 1'b0;
          r_s_pl    <= '0;
        end else if (flush) begin
          r_m_valid <= 1'b0;
          r_s_valid <= 1'b0;
        end else if (w_out_fire && r_s_valid) begin
          r_m_pl    <= r_s_pl;
          r_m_valid <= 1'b1;
          r_s_valid <= 1'b0;
        end else if (!r_m_valid || w_out_fire) begin
          // Payload only moves on a real transfer so bubbles keep the last bundle.
          if (w_in_fire) begin
            r_m_pl <= w_in_pl;
          end
          r_m_valid <= w_in_fire;
        end else if (w_in_fire) begin
          r_s_pl    <= w_in_pl;
          r_s_valid <= 1'b1;
        end
      end

      assign in_ready  = ~r_s_valid;
      assign out_count = {1'b0, r_m_valid} + {1'b0, r_s_valid};
    end else begin : g_noskid
      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          r_m_valid <= 1'b0;
          r_m_pl    <= '0;
        end else if (flush) begin
          r_m_valid <= 1'b0;
        end else if (!r_m_valid || w_out_fire) begin
          if (w_in_fire) begin
            r_m_pl <= w_in_pl;
          end
          r_m_valid <= w_in_fire;
        end
      end

      assign in_ready  = ~r_m_valid | out_ready;
      assign out_count = {1'b0, r_m_valid};
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_xm_skid_latch.sv
// ============================================================================
// Module : tb_xm_skid_latch
// Directed-vector bench for xm_skid_latch (SKID=1 default and SKID=0 wide).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_xm_skid_latch;

  typedef struct {
    logic        iv;
    logic        ordy;
    logic        fl;
    logic [7:0]  alu;
    logic [13:0] ctrl;
    logic [4:0]  rd;
    logic        ev;
    logic [7:0]  ealu;
    logic [13:0] ectrl;
    logic [4:0]  erd;
    logic [1:0]  ecnt;
    logic        erdy;
    logic        cpl;
  } vec_t;

  logic clock = 1'b0;
  logic reset = 1'b0;

  // SKID=1 instance, default widths
  logic        flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic        in_ready, out_valid;
  logic [31:0] in_pc_next = '0, in_pc_plus1 = '0, in_alu_result = '0, in_data_reg = '0;
  logic [13:0] in_ctrl = '0;
  logic [4:0]  in_rd = '0;
  logic [31:0] out_pc_next, out_pc_plus1, out_alu_result, out_data_reg;
  logic [13:0] out_ctrl;
  logic [4:0]  out_rd;
  logic [1:0]  out_count;

  // SKID=0 instance, PC_W=16, DATA_W=64
  logic        z_flush = 1'b0, z_in_valid = 1'b0, z_out_ready = 1'b0;
  logic        z_in_ready, z_out_valid;
  logic [15:0] z_in_pc_next = '0, z_in_pc_plus1 = '0;
  logic [63:0] z_in_alu_result = '0, z_in_data_reg = '0;
  logic [13:0] z_in_ctrl = '0;
  logic [4:0]  z_in_rd = '0;
  logic [15:0] z_out_pc_next, z_out_pc_plus1;
  logic [63:0] z_out_alu_result, z_out_data_reg;
  logic [13:0] z_out_ctrl;
  logic [4:0]  z_out_rd;
  logic [1:0]  z_out_count;

  int n_vec = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  xm_skid_latch dut (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc_next(in_pc_next), .in_pc_plus1(in_pc_plus1),
    .in_alu_result(in_alu_result), .in_data_reg(in_data_reg),
    .in_ctrl(in_ctrl), .in_rd(in_rd),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc_next(out_pc_next), .out_pc_plus1(out_pc_plus1),
    .out_alu_result(out_alu_result), .out_data_reg(out_data_reg),
    .out_ctrl(out_ctrl), .out_rd(out_rd), .out_count(out_count)
  );

  xm_skid_latch #(.PC_W(16), .DATA_W(64), .CTRL_W(14), .RD_W(5), .SKID(0)) dut0 (
    .clock(clock), .reset(reset), .flush(z_flush),
    .in_valid(z_in_valid), .in_ready(z_in_ready),
    .in_pc_next(z_in_pc_next), .in_pc_plus1(z_in_pc_plus1),
    .in_alu_result(z_in_alu_result), .in_data_reg(z_in_data_reg),
    .in_ctrl(z_in_ctrl), .in_rd(z_in_rd),
    .out_valid(z_out_valid), .out_ready(z_out_ready),
    .out_pc_next(z_out_pc_next), .out_pc_plus1(z_out_pc_plus1),
    .out_alu_result(z_out_alu_result), .out_data_reg(z_out_data_reg),
    .out_ctrl(z_out_ctrl), .out_rd(z_out_rd), .out_count(z_out_count)
  );

  task automatic chk(input int idx, input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL v%0d %s: got %h expected %h", idx, nm, act, exp);
    end
  endtask

  // Payload fields other than alu/ctrl/rd are derived from alu so one byte identifies a bundle.
  task automatic drive(input logic iv, input logic ordy, input logic fl,
                       input logic [7:0] alu, input logic [13:0] ctrl, input logic [4:0] rd);
    in_valid      = iv;
    out_ready     = ordy;
    flush         = fl;
    in_alu_result = {24'h0, alu};
    in_pc_next    = {24'h0, alu} + 32'h100;
    in_pc_plus1   = {24'h0, alu} + 32'h1;
    in_data_reg   = {24'hFFFFFF, ~alu};
    in_ctrl       = ctrl;
    in_rd         = rd;
  endtask

  task automatic chk_state(input int idx, input logic ev, input logic [7:0] ealu, input logic [13:0] ectrl,
                           input logic [4:0] erd, input logic [1:0] ecnt, input logic erdy, input logic cpl);
    chk(idx, "out_valid", 64'(out_valid), 64'(ev));
    chk(idx, "out_ctrl",  64'(out_ctrl),  64'(ectrl));
    chk(idx, "out_rd",    64'(out_rd),    64'(erd));
    chk(idx, "out_count", 64'(out_count), 64'(ecnt));
    chk(idx, "in_ready",  64'(in_ready),  64'(erdy));
    if (cpl) begin
      chk(idx, "out_alu_result", 64'(out_alu_result), 64'({24'h0, ealu}));
      chk(idx, "out_pc_next",    64'(out_pc_next),    64'({24'h0, ealu} + 32'h100));
      chk(idx, "out_pc_plus1",   64'(out_pc_plus1),   64'({24'h0, ealu} + 32'h1));
      chk(idx, "out_data_reg",   64'(out_data_reg),   64'({24'hFFFFFF, ~ealu}));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[21];

    for (int i = 0; i < 8; i++) begin
      tbl[i] = '{1'b1, 1'b1, 1'b0, 8'(8'h10 + i), 14'(14'h20 + i), 5'(i + 1),
                 1'b1, 8'(8'h10 + i), 14'(14'h20 + i), 5'(i + 1), 2'd1, 1'b1, 1'b1};
    end
    // backpressure: S takes 0x18, 0x19 waits, release drains 0x18 then 0x19, 0x1A
    tbl[8]  = '{1'b1, 1'b0, 1'b0, 8'h18, 14'h28, 5'd9,  1'b1, 8'h17, 14'h27, 5'd8,  2'd2, 1'b0, 1'b1};
    tbl[9]  = '{1'b1, 1'b0, 1'b0, 8'h19, 14'h29, 5'd10, 1'b1, 8'h17, 14'h27, 5'd8,  2'd2, 1'b0, 1'b1};
    tbl[10] = '{1'b1, 1'b0, 1'b0, 8'h19, 14'h29, 5'd10, 1'b1, 8'h17, 14'h27, 5'd8,  2'd2, 1'b0, 1'b1};
    tbl[11] = '{1'b1, 1'b1, 1'b0, 8'h19, 14'h29, 5'd10, 1'b1, 8'h18, 14'h28, 5'd9,  2'd1, 1'b1, 1'b1};
    tbl[12] = '{1'b1, 1'b1, 1'b0, 8'h19, 14'h29, 5'd10, 1'b1, 8'h19, 14'h29, 5'd10, 2'd1, 1'b1, 1'b1};
    tbl[13] = '{1'b1, 1'b1, 1'b0, 8'h1A, 14'h2A, 5'd11, 1'b1, 8'h1A, 14'h2A, 5'd11, 2'd1, 1'b1, 1'b1};
    // fill to 2, flush with rd=7 pending, then confirm it never appears
    tbl[14] = '{1'b1, 1'b0, 1'b0, 8'h1B, 14'h2B, 5'd12, 1'b1, 8'h1A, 14'h2A, 5'd11, 2'd2, 1'b0, 1'b1};
    tbl[15] = '{1'b1, 1'b0, 1'b1, 8'h77, 14'h77, 5'd7,  1'b0, 8'h00, 14'h0,  5'd0,  2'd0, 1'b1, 1'b0};
    tbl[16] = '{1'b0, 1'b1, 1'b0, 8'h00, 14'h0,  5'd0,  1'b0, 8'h00, 14'h0,  5'd0,  2'd0, 1'b1, 1'b0};
    // bubble after a full-ones ctrl/rd bundle is consumed
    tbl[17] = '{1'b1, 1'b0, 1'b0, 8'h40, 14'h3FFF, 5'd31, 1'b1, 8'h40, 14'h3FFF, 5'd31, 2'd1, 1'b1, 1'b1};
    tbl[18] = '{1'b0, 1'b1, 1'b0, 8'h00, 14'h0,    5'd0,  1'b0, 8'h40, 14'h0,    5'd0,  2'd0, 1'b1, 1'b1};
    // flush concurrent with out_fire and in_fire
    tbl[19] = '{1'b1, 1'b1, 1'b0, 8'h50, 14'h1,  5'd2,  1'b1, 8'h50, 14'h1,  5'd2,  2'd1, 1'b1, 1'b1};
    tbl[20] = '{1'b1, 1'b1, 1'b1, 8'h51, 14'h2,  5'd3,  1'b0, 8'h00, 14'h0,  5'd0,  2'd0, 1'b1, 1'b0};

    // reset state
    #12;
    chk(-1, "rst out_valid", 64'(out_valid), 64'd0);
    chk(-1, "rst out_count", 64'(out_count), 64'd0);
    chk(-1, "rst in_ready",  64'(in_ready),  64'd1);
    chk(-1, "rst payload",   {out_pc_next, out_alu_result} ^ {out_pc_plus1, out_data_reg} ^ 64'({out_ctrl, out_rd}), 64'd0);
    chk(-1, "rst z_in_ready", 64'(z_in_ready), 64'd1);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock); #1;

    for (int i = 0; i < 21; i++) begin
      drive(tbl[i].iv, tbl[i].ordy, tbl[i].fl, tbl[i].alu, tbl[i].ctrl, tbl[i].rd);
      @(posedge clock); #1;
      chk_state(i, tbl[i].ev, tbl[i].ealu, tbl[i].ectrl, tbl[i].erd, tbl[i].ecnt, tbl[i].erdy, tbl[i].cpl);
    end

    // asynchronous reset with two entries held
    drive(1'b1, 1'b0, 1'b0, 8'h60, 14'h60, 5'd4);
    @(posedge clock); #1;
    drive(1'b1, 1'b0, 1'b0, 8'h61, 14'h61, 5'd5);
    @(posedge clock); #1;
    chk(100, "pre-reset out_count", 64'(out_count), 64'd2);
    #2;
    reset = 1'b0;
    #1;
    chk(101, "async out_valid", 64'(out_valid), 64'd0);
    chk(101, "async out_count", 64'(out_count), 64'd0);
    chk(101, "async in_ready",  64'(in_ready),  64'd1);
    chk(101, "async pc",        {out_pc_next, out_pc_plus1}, 64'd0);
    chk(101, "async data",      {out_alu_result, out_data_reg}, 64'd0);
    chk(101, "async ctrl_rd",   64'({out_ctrl, out_rd}), 64'd0);
    @(negedge clock);
    reset = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 8'h70, 14'h70, 5'd6);
    @(posedge clock); #1;
    chk_state(102, 1'b1, 8'h70, 14'h70, 5'd6, 2'd1, 1'b1, 1'b1);
    drive(1'b0, 1'b1, 1'b0, 8'h00, 14'h0, 5'd0);
    @(posedge clock); #1;

    // SKID=0, wide data, combinational in_ready
    z_in_valid      = 1'b1;
    z_out_ready     = 1'b1;
    z_in_pc_next    = 16'h1234;
    z_in_pc_plus1   = 16'h1235;
    z_in_alu_result = 64'hDEADBEEF_CAFEF00D;
    z_in_data_reg   = 64'h01234567_89ABCDEF;
    z_in_ctrl       = 14'h5;
    z_in_rd         = 5'd3;
    #1;
    chk(200, "z in_ready empty", 64'(z_in_ready), 64'd1);
    @(posedge clock); #1;
    chk(201, "z out_valid",  64'(z_out_valid), 64'd1);
    chk(201, "z alu",        z_out_alu_result, 64'hDEADBEEF_CAFEF00D);
    chk(201, "z data",       z_out_data_reg,   64'h01234567_89ABCDEF);
    chk(201, "z pcs",        64'({z_out_pc_next, z_out_pc_plus1}), 64'h12341235);
    chk(201, "z ctrl_rd",    64'({z_out_ctrl, z_out_rd}), 64'({14'h5, 5'd3}));
    chk(201, "z out_count",  64'(z_out_count), 64'd1);
    z_in_alu_result = 64'h11112222_33334444;
    z_in_ctrl       = 14'h9;
    z_out_ready     = 1'b0;
    #1;
    chk(202, "z in_ready stall", 64'(z_in_ready), 64'd0);
    z_out_ready = 1'b1;
    #1;
    chk(203, "z in_ready follow", 64'(z_in_ready), 64'd1);
    z_out_ready = 1'b0;
    @(posedge clock); #1;
    chk(204, "z hold alu",   z_out_alu_result, 64'hDEADBEEF_CAFEF00D);
    chk(204, "z hold count", 64'(z_out_count), 64'd1);
    z_out_ready = 1'b1;
    @(posedge clock); #1;
    chk(205, "z next alu",   z_out_alu_result, 64'h11112222_33334444);
    chk(205, "z next ctrl",  64'(z_out_ctrl), 64'h9);
    z_in_valid = 1'b0;
    @(posedge clock); #1;
    chk(206, "z bubble valid", 64'(z_out_valid), 64'd0);
    chk(206, "z bubble ctrl",  64'({z_out_ctrl, z_out_rd}), 64'd0);
    chk(206, "z bubble count", 64'(z_out_count), 64'd0);
    chk(206, "z bubble alu",   z_out_alu_result, 64'h11112222_33334444);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
